mem_sweep_reader: RTL and testbench
===================================

// Module: mem_sweep_reader
// PURPOSE
//   Read-side companion to the block-RAM "memory" wrapper. On a start pulse, sweeps an address window of the RAM.
//   Drives raddr and absorbs the RAM's 1-cycle registered read latency.
//   Emits each word with its address on a valid/ready stream with full backpressure.
//   Folds all emitted words into an XOR checksum, so a readback after bitstream reinit can be checked against the init file.
// PARAMETERS
//   WID_MEM    1      data width of the swept RAM (matches memory.WID_MEM)
//   DEPTH_MEM  65536  RAM depth in words; addresses wrap modulo DEPTH_MEM
//   ADDR_W     16     address width; DEPTH_MEM <= 2**ADDR_W
// PORTS
//   clk         in   1        clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        1-cycle pulse: begin sweep; ignored while busy=1
//   first_addr  in   ADDR_W   first address of window; sampled on accepted start
//   last_addr   in   ADDR_W   last address of window (inclusive); sampled on accepted start
//   mem_raddr   out  ADDR_W   to memory.raddr; zero-extended to 32b at instantiation
//   mem_rdata   in   WID_MEM  from memory.dout; valid 1 clk after mem_raddr
//   m_valid     out  1        output word valid
//   m_ready     in   1        downstream accepts; transfer = m_valid & m_ready
//   m_data      out  WID_MEM  word read from RAM
//   m_addr      out  ADDR_W   address m_data came from
//   m_last      out  1        marks final word of sweep
//   busy        out  1        high from accepted start until done
//   done        out  1        1-cycle pulse after final transfer
//   checksum    out  WID_MEM  XOR of all m_data transferred this sweep; stable after done
// BEHAVIOUR
//   Reset (async): FSM=IDLE; mem_raddr=0, m_valid=0, m_data=0, m_addr=0, m_last=0, busy=0, done=0, checksum=0; FIFO emptied.
//   Word count N = ((last_addr - first_addr) mod DEPTH_MEM) + 1.
//     first_addr == last_addr gives N=1.
//     last_addr < first_addr wraps through DEPTH_MEM-1 -> 0.
//   FSM:
//     IDLE -> ISSUE on start. Latch window, clear checksum, busy=1.
//     ISSUE -> DRAIN once all N reads are issued.
//     DRAIN -> IDLE when the m_last word transfers. done=1 in the following cycle; busy=0 in the same cycle as done.
//   Read issue: one read per cycle max, address increments modulo DEPTH_MEM.
//     Issue only if (words in flight + words in output FIFO) < 2, so no data is ever lost under backpressure.
//   Data path: read issued on cycle T; mem_rdata captured on T+1 into a 2-entry output FIFO together with its address.
//     m_* is driven from the FIFO head; m_last = head is word N.
//   Throughput: with m_ready held at 1, one word per cycle.
//     First m_valid occurs 2 cycles after start (start edge -> raddr issue -> capture).
//   Stream rules:
//     m_valid, once high, is held until transfer.
//     m_data, m_addr and m_last are stable while m_valid & !m_ready.
//   checksum ^= m_data on each transfer only; holds its value in IDLE until the next accepted start.
//   start while busy is ignored; first_addr and last_addr are not resampled.
//   Reset mid-sweep: abort immediately. No done pulse; m_valid=0 the next cycle, FIFO contents dropped.
//   Concurrent writes to the RAM during a sweep are not the block's concern.
//     Reads return whatever the RAM's read-first port returns.
//   Addresses >= DEPTH_MEM on first_addr or last_addr are reduced modulo DEPTH_MEM.
// TESTING
//   1. RAM init 0..15 = 0x1..0x10 (WID_MEM=8, DEPTH=16), window 0..15, m_ready=1
//      -> 16 beats, addr 0..15, data 1..16 back-to-back; first m_valid at start+2.
//      -> m_last on addr 15; done 1 cycle after that beat; checksum=0x10.
//   2. Same as 1, with m_ready toggling 1-0-0-1 randomly
//      -> identical sequence, no drops/duplicates; m_data stable while stalled; at most 2 reads outstanding.
//   3. Window first=14, last=1, DEPTH=16 -> 4 beats, addr 14,15,0,1; m_last on addr 1.
//   4. first=last=5 -> single beat with m_last=1, checksum=ram[5]; start pulsed again mid-sweep is ignored (N unchanged).
//   5. Assert reset while m_valid & !m_ready at beat 7
//      -> all outputs return to reset values asynchronously; no done pulse.
//      -> a new start after reset sweeps correctly from its own first_addr.
//   6. WID_MEM=1, DEPTH=65536, all-ones init, full window
//      -> 65536 beats, wrap-free, checksum=0; busy high throughout.

Source files
------------

// File: rtl/mem_sweep_reader.sv
// rtl/mem_sweep_reader.sv - sweeps an address window of a block RAM onto a valid/ready stream
//
// Purpose:
//   On an accepted start pulse, reads every word of the window [first_addr .. last_addr]
//   (inclusive, wrapping modulo DEPTH_MEM) from a RAM with a 1-cycle registered read port.
//   Each word is emitted with its address on a backpressured stream. An XOR checksum of all
//   transferred words is kept, so a readback can be compared against a known init image.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   start       in   1-cycle pulse, begins a sweep; ignored while busy
//   first_addr  in   first address of window, sampled on accepted start
//   last_addr   in   last address of window (inclusive), sampled on accepted start
//   mem_raddr   out  RAM read address
//   mem_rdata   in   RAM read data, valid 1 clk after mem_raddr
//   m_valid     out  stream word valid
//   m_ready     in   stream downstream ready
//   m_data      out  word read from RAM
//   m_addr      out  address m_data came from
//   m_last      out  final word of the sweep
//   busy        out  high from accepted start until done
//   done        out  1-cycle pulse after the final transfer
//   checksum    out  XOR of all words transferred this sweep

module mem_sweep_reader #(
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic [WID_MEM-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // One extra bit so that a word count equal to DEPTH_MEM is representable.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH_MEM);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W+1)'(1);

  state_t state, state_nxt;

  logic              accept_start;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [1:0]        occupancy;

  logic [ADDR_W-1:0] first_red;
  logic [ADDR_W-1:0] last_red;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   remaining;     // reads still to be issued

  // The read presented on mem_raddr last cycle; its data is on mem_rdata this cycle.
  logic              inflight;
  logic              inflight_last;
  logic [ADDR_W-1:0] inflight_addr;

  // 2-entry output FIFO, circular with 1-bit pointers.
  logic [WID_MEM-1:0] fifo_data [2];
  logic [ADDR_W-1:0]  fifo_addr [2];
  logic [1:0]         fifo_last;
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fifo_cnt;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} == DEPTH_V - ONE_V) begin
      return '0;
    end
    return a + ADDR_W'(1);
  endfunction

  // Window reduction and word count.
  always_comb begin
    first_red = ADDR_W'({1'b0, first_addr} % DEPTH_V);
    last_red  = ADDR_W'({1'b0, last_addr} % DEPTH_V);
    if (last_red >= first_red) begin
      word_cnt = {1'b0, last_red} - {1'b0, first_red} + ONE_V;
    end else begin
      word_cnt = {1'b0, last_red} + DEPTH_V - {1'b0, first_red} + ONE_V;
    end
  end

  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_addr  = fifo_addr[rd_ptr];
  assign m_last  = m_valid & fifo_last[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign busy    = (state != S_IDLE);

  // Occupancy after this cycle's pop. Issuing only when it is below 2 guarantees the
  // word arriving next cycle always finds room, yet still allows one issue per cycle
  // while the head is being accepted.
  assign occupancy  = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue      = (state == S_ISSUE) && (occupancy < 2'd2);
  assign issue_last = (remaining == ONE_V);

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue && issue_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_raddr     <= '0;
      remaining     <= '0;
      checksum      <= '0;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_addr <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
      fifo_last     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      done <= (state == S_DRAIN) && pop && m_last;

      // Start, issue and pop are mutually exclusive with accept_start: the FIFO is
      // empty and nothing is issued while idle.
      if (accept_start) begin
        mem_raddr <= first_red;
        remaining <= word_cnt;
        checksum  <= '0;
      end else begin
        if (issue) begin
          mem_raddr <= next_addr(mem_raddr);
          remaining <= remaining - ONE_V;
        end
        if (pop) begin
          checksum <= checksum ^ m_data;
        end
      end

      inflight <= issue;
      if (issue) begin
        inflight_addr <= mem_raddr;
        inflight_last <= issue_last;
      end

      if (inflight) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_addr[wr_ptr] <= inflight_addr;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_sweep_reader.sv
// tb/tb_mem_sweep_reader.sv - self-checking bench for mem_sweep_reader

module tb_mem_sweep_reader;
  localparam int WID   = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  first_addr = '0;
  logic [AW-1:0]  last_addr = '0;
  logic [AW-1:0]  mem_raddr;
  logic [WID-1:0] mem_rdata = '0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [WID-1:0] m_data;
  logic [AW-1:0]  m_addr;
  logic           m_last;
  logic           busy;
  logic           done;
  logic [WID-1:0] checksum;

  logic [WID-1:0] ram [DEPTH];

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [WID-1:0] data;
    logic           last;
  } beat_t;

  beat_t          exp_q[$];
  beat_t          e;
  beat_t          held;
  logic           stalled = 1'b0;
  logic [WID-1:0] model_ck = '0;
  int n_cmp = 0;
  int n_fail = 0;
  int rmode = 0;
  int beats = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  mem_sweep_reader #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Registered-read RAM.
  always @(posedge clk) mem_rdata <= ram[mem_raddr[3:0]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rmode == 0) m_ready = 1'b1;
    else if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_beat", 32'({m_addr, m_data, m_last}), 32'(held));
      end
      if (m_valid) check("busy_while_valid", 32'(busy), 32'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_beat: got addr 0x%0h data 0x%0h with no word expected", m_addr, m_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 32'(m_addr), 32'(e.addr));
          check("beat_data", 32'(m_data), 32'(e.data));
          check("beat_last", 32'(m_last), 32'(e.last));
          model_ck = model_ck ^ e.data;
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
        end
      end
      stalled = m_valid && !m_ready;
      held    = {m_addr, m_data, m_last};
      if (done) begin
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_checksum", 32'(checksum), 32'(model_ck));
        done_cnt++;
      end
    end
  end

  task automatic load_model(input int f, input int l);
    int fr, lr, n, a;
    fr = f % DEPTH;
    lr = l % DEPTH;
    n  = ((lr - fr + DEPTH) % DEPTH) + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = (fr + i) % DEPTH;
      exp_q.push_back({AW'(a), ram[a], (i == n - 1)});
    end
    model_ck = '0;
    beats = 0;
  endtask

  task automatic sweep(input int f, input int l, input int mode, input bit restart,
                       input logic [WID-1:0] exp_ck, input int exp_n);
    int d0;
    load_model(f, l);
    d0 = done_cnt;
    rmode = mode;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_edge0", 32'(m_valid), 32'd0);
    if (restart) begin
      first_addr = AW'(9);
      last_addr  = AW'(12);
    end else begin
      start = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_edge1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_edge2", 32'(m_valid), 32'd1);
    check("first_m_addr", 32'(m_addr), 32'(f % DEPTH));
    for (int c = 0; c < 400 && done_cnt == d0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("beat_count", 32'(beats), 32'(exp_n));
    check("checksum", 32'(checksum), 32'(exp_ck));
    check("busy_idle", 32'(busy), 32'd0);
    if (mode == 0) check("throughput", 32'(last_cyc - first_cyc), 32'(exp_n - 1));
  endtask

  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i + 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    sweep(0, 15, 0, 1'b0, 8'h10, 16);
    sweep(0, 15, 1, 1'b0, 8'h10, 16);
    sweep(14, 1, 0, 1'b0, 8'h1c, 4);
    sweep(5, 5, 0, 1'b1, 8'h06, 1);
    sweep(20, 22, 1, 1'b0, 8'h04, 3);

    // Reset while the word at address 7 is stalled.
    load_model(0, 15);
    d0 = done_cnt;
    rmode = 2;
    m_ready = 1'b1;
    first_addr = AW'(0);
    last_addr  = AW'(15);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && beats < 7; c++) @(posedge clk);
    #1;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_addr", 32'(m_addr), 32'd7);
    check("stall_data", 32'(m_data), 32'd8);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_checksum", 32'(checksum), 32'd0);
    check("abort_raddr", 32'(mem_raddr), 32'd0);
    check("abort_m_data", 32'(m_data), 32'd0);
    check("abort_m_addr", 32'(m_addr), 32'd0);
    check("abort_m_last", 32'(m_last), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rmode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_valid", 32'(m_valid), 32'd0);

    sweep(3, 8, 0, 1'b0, 8'h01, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
